// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings: instruction codes, ALU and condition function
// codes, processor status codes and the sequencer state type.
package y86_pkg;

  localparam logic [3:0] ICODE_HALT   = 4'h0;
  localparam logic [3:0] ICODE_NOP    = 4'h1;
  localparam logic [3:0] ICODE_CMOVXX = 4'h2;
  localparam logic [3:0] ICODE_IRMOVQ = 4'h3;
  localparam logic [3:0] ICODE_RMMOVQ = 4'h4;
  localparam logic [3:0] ICODE_MRMOVQ = 4'h5;
  localparam logic [3:0] ICODE_OPQ    = 4'h6;
  localparam logic [3:0] ICODE_JXX    = 4'h7;
  localparam logic [3:0] ICODE_CALL   = 4'h8;
  localparam logic [3:0] ICODE_RET    = 4'h9;
  localparam logic [3:0] ICODE_PUSHQ  = 4'hA;
  localparam logic [3:0] ICODE_POPQ   = 4'hB;

  localparam logic [3:0] ALU_ADD = 4'h0;
  localparam logic [3:0] ALU_SUB = 4'h1;
  localparam logic [3:0] ALU_AND = 4'h2;
  localparam logic [3:0] ALU_XOR = 4'h3;

  localparam logic [3:0] COND_ALWAYS = 4'h0;
  localparam logic [3:0] COND_LE     = 4'h1;
  localparam logic [3:0] COND_L      = 4'h2;
  localparam logic [3:0] COND_E      = 4'h3;
  localparam logic [3:0] COND_NE     = 4'h4;
  localparam logic [3:0] COND_GE     = 4'h5;
  localparam logic [3:0] COND_G      = 4'h6;

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  // cc bit order is {ZF, SF, OF}; reset leaves ZF set
  localparam logic [2:0] CC_RESET = 3'b100;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXECUTE,
    ST_MEMORY,
    ST_WRITEBACK,
    ST_PC_UPD,
    ST_HALTED
  } state_t;

endpackage

// File: rtl/cond_eval.sv
// Branch / conditional-move condition from the {ZF, SF, OF} flags.
// Purely combinational so a pipelined core can reuse it as-is.
module cond_eval
  import y86_pkg::*;
(
  input  logic [2:0] cc,
  input  logic [3:0] fun,
  output logic       cnd
);

  logic zf, sf, of_flag;
  assign zf      = cc[2];
  assign sf      = cc[1];
  assign of_flag = cc[0];

  // decode the condition; undefined function codes never fire
  always_comb begin
    cnd = 1'b0;
    case (fun)
      COND_ALWAYS: cnd = 1'b1;
      COND_LE:     cnd = (sf ^ of_flag) | zf;
      COND_L:      cnd = sf ^ of_flag;
      COND_E:      cnd = zf;
      COND_NE:     cnd = ~zf;
      COND_GE:     cnd = ~(sf ^ of_flag);
      COND_G:      cnd = ~(sf ^ of_flag) & ~zf;
      default:     cnd = 1'b0;
    endcase
  end

endmodule

// File: rtl/seq_stage_ctrl.sv
// Multi-cycle SEQ sequencer: steps one-hot stage enables, owns the
// condition codes, the registered cnd, processor status and retire count.
//
// state     | meaning
// IDLE      | waiting for start
// FETCH     | fetch enabled; fault / halt checks on exit
// DECODE    | decode enabled
// EXECUTE   | execute enabled; cc and cnd updated on exit
// MEMORY    | memory enabled; data fault check on exit
// WRITEBACK | register writeback enabled
// PC_UPD    | PC update enabled; instruction retires on exit
// HALTED    | stopped with final stat until reset
module seq_stage_ctrl
  import y86_pkg::*;
#(
  parameter int CNT_W = 64
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       in_code,
  input  logic [3:0]       in_fun,
  input  logic [63:0]      val_a,
  input  logic [63:0]      val_b,
  input  logic [63:0]      val_e,
  input  logic             instr_valid,
  input  logic             imem_error,
  input  logic             dmem_error,
  output logic             fetch_en,
  output logic             decode_en,
  output logic             exec_en,
  output logic             mem_en,
  output logic             wb_en,
  output logic             pc_en,
  output logic [2:0]       cc,
  output logic             cnd,
  output logic [2:0]       stat,
  output logic             halted,
  output logic [CNT_W-1:0] instr_count
);

  state_t            state_q, state_d;
  logic [2:0]        cc_q, cc_d;
  logic              cnd_q, cnd_d;
  logic [2:0]        stat_q, stat_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic              cnd_eval;
  logic              alu_of;
  logic              a_neg, b_neg, e_neg;
  logic              unused_operand_bits;

  assign a_neg = val_a[63];
  assign b_neg = val_b[63];
  assign e_neg = val_e[63];
  // only the sign bits of the operands matter for overflow
  assign unused_operand_bits = ^{val_a[62:0], val_b[62:0]};

  // condition uses the flags as they stood before this EXECUTE
  cond_eval u_cond_eval (
    .cc  (cc_q),
    .fun (in_fun),
    .cnd (cnd_eval)
  );

  // signed overflow of the ALU result; logical ops never overflow
  always_comb begin
    alu_of = 1'b0;
    case (in_fun)
      ALU_ADD: alu_of = (a_neg == b_neg) && (e_neg != a_neg);
      ALU_SUB: alu_of = (a_neg != b_neg) && (e_neg != b_neg);
      default: alu_of = 1'b0;
    endcase
  end

  // next-state and architectural updates
  always_comb begin
    state_d = state_q;
    cc_d    = cc_q;
    cnd_d   = cnd_q;
    stat_d  = stat_q;
    count_d = count_q;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (imem_error) begin
          stat_d  = STAT_ADR;
          state_d = ST_HALTED;
        end else if (!instr_valid) begin
          stat_d  = STAT_INS;
          state_d = ST_HALTED;
        end else if (in_code == ICODE_HALT) begin
          stat_d  = STAT_HLT;
          state_d = ST_HALTED;
        end else begin
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: state_d = ST_EXECUTE;
      ST_EXECUTE: begin
        state_d = ST_MEMORY;
        if (in_code == ICODE_OPQ) cc_d = {(val_e == '0), e_neg, alu_of};
        if (in_code == ICODE_CMOVXX || in_code == ICODE_JXX) cnd_d = cnd_eval;
        else cnd_d = 1'b0;
      end
      ST_MEMORY: begin
        if (dmem_error) begin
          stat_d  = STAT_ADR;
          state_d = ST_HALTED;
        end else begin
          state_d = ST_WRITEBACK;
        end
      end
      ST_WRITEBACK: state_d = ST_PC_UPD;
      ST_PC_UPD: begin
        count_d = count_q + 1'b1;
        state_d = ST_FETCH;
      end
      ST_HALTED: state_d = ST_HALTED;
      default:   state_d = ST_IDLE;
    endcase
  end

  // state and architectural registers; reset aborts any instruction in flight
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cc_q    <= CC_RESET;
      cnd_q   <= 1'b0;
      stat_q  <= STAT_AOK;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      cc_q    <= cc_d;
      cnd_q   <= cnd_d;
      stat_q  <= stat_d;
      count_q <= count_d;
    end
  end

  // Moore decode of the stage enables
  always_comb begin
    fetch_en  = 1'b0;
    decode_en = 1'b0;
    exec_en   = 1'b0;
    mem_en    = 1'b0;
    wb_en     = 1'b0;
    pc_en     = 1'b0;
    case (state_q)
      ST_FETCH:     fetch_en  = 1'b1;
      ST_DECODE:    decode_en = 1'b1;
      ST_EXECUTE:   exec_en   = 1'b1;
      ST_MEMORY:    mem_en    = 1'b1;
      ST_WRITEBACK: wb_en     = 1'b1;
      ST_PC_UPD:    pc_en     = 1'b1;
      default:      ;
    endcase
  end

  assign cc          = cc_q;
  assign cnd         = cnd_q;
  assign stat        = stat_q;
  assign halted      = (state_q == ST_HALTED);
  assign instr_count = count_q;

endmodule

// File: tb/tb_seq_stage_ctrl.sv
// Scoreboard bench for seq_stage_ctrl: the driver issues instructions and
// pushes the outcome predicted by a flag/arithmetic model; the monitor pops
// and compares whenever an instruction retires (pc_en) or the core halts.
module tb_seq_stage_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  in_code = '0;
  logic [3:0]  in_fun = '0;
  logic [63:0] val_a = '0, val_b = '0, val_e = '0;
  logic        instr_valid = 1'b1;
  logic        imem_error = 1'b0;
  logic        dmem_error = 1'b0;
  logic        fetch_en, decode_en, exec_en, mem_en, wb_en, pc_en;
  logic [2:0]  cc;
  logic        cnd;
  logic [2:0]  stat;
  logic        halted;
  logic [63:0] instr_count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          is_halt;
    logic [2:0]  cc;
    logic        cnd;
    logic [2:0]  stat;
    logic [63:0] count;
  } exp_t;
  exp_t sb_q[$];

  // reference model state
  bit          m_zf, m_sf, m_of;
  bit          m_cnd;
  logic [2:0]  m_stat;
  logic [63:0] m_count;

  seq_stage_ctrl #(.CNT_W(64)) dut (
    .clock(clock), .reset(reset), .start(start),
    .in_code(in_code), .in_fun(in_fun),
    .val_a(val_a), .val_b(val_b), .val_e(val_e),
    .instr_valid(instr_valid), .imem_error(imem_error), .dmem_error(dmem_error),
    .fetch_en(fetch_en), .decode_en(decode_en), .exec_en(exec_en),
    .mem_en(mem_en), .wb_en(wb_en), .pc_en(pc_en),
    .cc(cc), .cnd(cnd), .stat(stat), .halted(halted),
    .instr_count(instr_count)
  );

  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [5:0] en_vec();
    return {fetch_en, decode_en, exec_en, mem_en, wb_en, pc_en};
  endfunction

  // Y86 branch semantics after a compare-style op: "less" means the true
  // signed difference is negative, i.e. the sign flag disagrees with overflow.
  function automatic bit cond_holds(input logic [3:0] fun);
    bit less, equal;
    less  = (m_sf != m_of);
    equal = m_zf;
    case (fun)
      4'd0: return 1'b1;
      4'd1: return less || equal;
      4'd2: return less;
      4'd3: return equal;
      4'd4: return !equal;
      4'd5: return !less;
      4'd6: return !less && !equal;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_reset();
    m_zf = 1; m_sf = 0; m_of = 0; m_cnd = 0; m_stat = 3'd1; m_count = '0;
  endtask

  // Must be called at a negedge while the DUT is in FETCH.
  task automatic run_instr(input logic [3:0] code, input logic [3:0] fun,
                           input logic [63:0] a, input logic [63:0] b,
                           input logic [63:0] e, input bit valid,
                           input bit imem, input bit dmem, output bit did_halt);
    exp_t x;
    longint sa, sb, se;
    bit early;
    in_code = code; in_fun = fun; val_a = a; val_b = b; val_e = e;
    instr_valid = valid; imem_error = imem; dmem_error = dmem;
    check("fetch_en", en_vec(), 6'b100000);
    early = 1;
    if (imem)              m_stat = 3'd3;
    else if (!valid)       m_stat = 3'd4;
    else if (code == 4'd0) m_stat = 3'd2;
    else                   early = 0;
    did_halt = early;
    if (!early) begin
      m_cnd = (code == 4'd2 || code == 4'd7) ? cond_holds(fun) : 1'b0;
      if (code == 4'd6) begin
        sa = a; sb = b; se = e;
        m_zf = (se == 0);
        m_sf = (se < 0);
        if (fun == 4'd0)
          m_of = (sa >= 0 && sb >= 0 && se < 0) || (sa < 0 && sb < 0 && se >= 0);
        else if (fun == 4'd1)
          m_of = (sb >= 0 && sa < 0 && se < 0) || (sb < 0 && sa >= 0 && se >= 0);
        else
          m_of = 0;
      end
      if (dmem) begin
        m_stat = 3'd3;
        did_halt = 1;
      end
    end
    x.is_halt = did_halt;
    x.cc = {m_zf, m_sf, m_of};
    x.cnd = m_cnd;
    x.stat = m_stat;
    x.count = m_count;
    sb_q.push_back(x);
    @(negedge clock);
    if (early) begin
      check("en_after_fetch_halt", en_vec(), 6'b000000);
      return;
    end
    check("decode_en", en_vec(), 6'b010000);
    @(negedge clock);
    check("exec_en", en_vec(), 6'b001000);
    @(negedge clock);
    check("mem_en", en_vec(), 6'b000100);
    @(negedge clock);
    if (dmem) begin
      check("en_after_dmem_halt", en_vec(), 6'b000000);
      return;
    end
    check("wb_en", en_vec(), 6'b000010);
    @(negedge clock);
    check("pc_en", en_vec(), 6'b000001);
    m_count = m_count + 1;
    @(negedge clock);
  endtask

  task automatic do_reset_and_check();
    reset = 1'b1;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    model_reset();
    check("rst_en", en_vec(), 6'b000000);
    check("rst_cc", cc, 3'b100);
    check("rst_cnd", cnd, 1'b0);
    check("rst_stat", stat, 3'd1);
    check("rst_halted", halted, 1'b0);
    check("rst_count", instr_count, 64'd0);
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  // HALTED must ignore start and hold stat and count
  task automatic check_halted_hold();
    for (int i = 0; i < 3; i++) begin
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      check("halt_hold_halted", halted, 1'b1);
      check("halt_hold_stat", stat, m_stat);
      check("halt_hold_en", en_vec(), 6'b000000);
      check("halt_hold_count", instr_count, m_count);
    end
  endtask

  // monitor: compares each retirement / halt event against the queue
  bit halted_prev = 0;
  always @(negedge clock) begin
    exp_t x;
    if (reset) begin
      halted_prev = 0;
    end else begin
      if (pc_en || (halted && !halted_prev)) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected_event: pc_en=%0b halted=%0b with empty queue", pc_en, halted);
        end else begin
          x = sb_q.pop_front();
          check("sb_kind", {63'd0, halted}, {63'd0, x.is_halt});
          check("sb_cc", cc, x.cc);
          check("sb_cnd", cnd, x.cnd);
          check("sb_stat", stat, x.stat);
          check("sb_count", instr_count, x.count);
        end
      end
      halted_prev = halted;
    end
  end

  initial begin
    bit h;
    logic [3:0]  code, fun;
    logic [63:0] a, b, e;
    bit valid, imem, dmem;
    model_reset();
    @(negedge clock);
    do_reset_and_check();
    do_start();

    // directed sequence
    run_instr(4'd6, 4'd1, 64'd10, 64'd50, 64'd40, 1, 0, 0, h);
    run_instr(4'd6, 4'd1, 64'd50, 64'd50, 64'd0, 1, 0, 0, h);
    run_instr(4'd2, 4'd3, 64'd0, 64'd0, 64'd0, 1, 0, 0, h);
    run_instr(4'd2, 4'd4, 64'd0, 64'd0, 64'd0, 1, 0, 0, h);
    run_instr(4'd6, 4'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'h8000_0000_0000_0000, 1, 0, 0, h);
    run_instr(4'd7, 4'd2, 64'd0, 64'd0, 64'd0, 1, 0, 0, h);
    run_instr(4'd7, 4'd1, 64'd0, 64'd0, 64'd0, 1, 0, 0, h);
    run_instr(4'd0, 4'd0, 64'd0, 64'd0, 64'd0, 1, 0, 0, h);
    @(negedge clock);
    check_halted_hold();
    do_reset_and_check();
    do_start();
    run_instr(4'd1, 4'd0, 64'd0, 64'd0, 64'd0, 1, 1, 0, h);
    check_halted_hold();
    do_reset_and_check();
    do_start();
    run_instr(4'd1, 4'd0, 64'd0, 64'd0, 64'd0, 0, 0, 0, h);
    check_halted_hold();
    do_reset_and_check();
    do_start();
    run_instr(4'd6, 4'd1, 64'd3, 64'd3, 64'd0, 1, 0, 1, h);
    check_halted_hold();
    do_reset_and_check();
    do_start();

    // randomized instructions
    for (int n = 0; n < 250; n++) begin
      code = 4'($urandom_range(0, 11));
      if (code == 4'd0 && $urandom_range(0, 3) != 0) code = 4'd6;
      if ($urandom_range(0, 2) == 0) code = ($urandom_range(0, 1) == 1) ? 4'd2 : 4'd7;
      fun = (code == 4'd6) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 8));
      case ($urandom_range(0, 3))
        0: begin a = 64'h7FFF_FFFF_FFFF_FFFF; b = {$urandom, $urandom}; end
        1: begin a = {$urandom, $urandom}; b = 64'h8000_0000_0000_0000; end
        2: begin a = 64'($urandom_range(0, 3)); b = 64'($urandom_range(0, 3)); end
        default: begin a = {$urandom, $urandom}; b = {$urandom, $urandom}; end
      endcase
      case (fun)
        4'd0: e = a + b;
        4'd1: e = b - a;
        4'd2: e = a & b;
        default: e = a ^ b;
      endcase
      if ($urandom_range(0, 9) == 0) e = {$urandom, $urandom};
      valid = ($urandom_range(0, 39) != 0);
      imem  = ($urandom_range(0, 39) == 0);
      dmem  = ($urandom_range(0, 39) == 0);
      run_instr(code, fun, a, b, e, valid, imem, dmem, h);
      if (h) begin
        if (!halted) @(negedge clock);
        check_halted_hold();
        do_reset_and_check();
        do_start();
      end
    end

    // reset during EXECUTE of an OPq producing zero aborts the instruction
    run_instr(4'd6, 4'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'h8000_0000_0000_0000, 1, 0, 0, h);
    run_instr(4'd7, 4'd0, 64'd0, 64'd0, 64'd0, 1, 0, 0, h);
    in_code = 4'd6; in_fun = 4'd1; val_a = 64'd5; val_b = 64'd5; val_e = 64'd0;
    instr_valid = 1; imem_error = 0; dmem_error = 0;
    check("abort_fetch_en", en_vec(), 6'b100000);
    @(negedge clock);
    @(negedge clock);
    check("abort_exec_en", en_vec(), 6'b001000);
    reset = 1'b1;
    @(negedge clock);
    check("abort_en", en_vec(), 6'b000000);
    check("abort_cc", cc, 3'b100);
    check("abort_cnd", cnd, 1'b0);
    check("abort_stat", stat, 3'd1);
    check("abort_count", instr_count, 64'd0);
    check("abort_halted", halted, 1'b0);
    reset = 1'b0;
    model_reset();
    @(negedge clock);
    check("idle_stays", en_vec(), 6'b000000);

    repeat (3) @(negedge clock);
    check("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_stage_ctrl.md
Name: seq_stage_ctrl

Overview:
Multi-cycle sequencer for the Y86-64 SEQ core. It steps the stage enables in order (fetch, decode, execute, memory, writeback, PC update) and owns the condition-code register (ZF/SF/OF) that the execute ALU result updates. It produces the registered branch/cmov condition `cnd` and tracks processor status (AOK/HLT/ADR/INS). It sits beside the execute stage and drives every stage's enable.

Parameters:
CNT_W, 64, width of the retired-instruction counter

Ports:
clock  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high; wins over every other input
start  input  1  pulse in IDLE begins execution
in_code  input  4  icode of the current instruction (from fetch)
in_fun  input  4  ifun of the current instruction
val_a  input  64  ALU operand A, signed
val_b  input  64  ALU operand B, signed
val_e  input  64  ALU result from execute, signed
instr_valid  input  1  fetch decoded a legal icode/ifun
imem_error  input  1  fetch address fault
dmem_error  input  1  data memory fault, sampled in MEMORY
fetch_en, decode_en, exec_en, mem_en, wb_en, pc_en  output  1 each  one-hot stage enables
cc  output  3  {ZF, SF, OF}
cnd  output  1  registered condition for the current jXX/cmovXX
stat  output  3  1=AOK, 2=HLT, 3=ADR, 4=INS
halted  output  1  high in HALTED
instr_count  output  CNT_W  retired instructions

Behaviour:
- Reset, synchronous and active-high: state=IDLE, all enables 0, cc=3'b100 (ZF=1), cnd=0, stat=AOK, halted=0, instr_count=0. A reset asserted mid-instruction aborts the instruction with no cc, count or stat update.
- States: IDLE, FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, PC_UPD, HALTED. Each active state lasts exactly one cycle. Enables are a Moore decode of the state: exactly one is high in FETCH through PC_UPD, and none in IDLE or HALTED.
- IDLE -> FETCH when start=1. Otherwise stay in IDLE.
- FETCH exit checks, in priority order:
  - imem_error=1 -> stat=ADR, go to HALTED.
  - instr_valid=0 -> stat=INS, go to HALTED.
  - in_code=0 (halt) -> stat=HLT, go to HALTED.
  - Otherwise -> DECODE.
- In every HALTED case the PC is not updated and instr_count is unchanged.
- DECODE -> EXECUTE -> MEMORY, unconditionally.
- EXECUTE, on the exit edge:
  - If in_code=6 (OPq): ZF = (val_e==0), SF = val_e[63].
  - OF for addq (fun 0) = (a[63]==b[63]) && (e[63]!=a[63]).
  - OF for subq (fun 1, e=b-a) = (a[63]!=b[63]) && (e[63]!=b[63]).
  - OF for andq/xorq = 0.
  - For any other in_code, cc is held.
  - cnd is latched only when in_code=2 or 7, using cc before this cycle's update, by fun:
    - 0 -> 1
    - 1 -> (SF^OF)|ZF
    - 2 -> SF^OF
    - 3 -> ZF
    - 4 -> ~ZF
    - 5 -> ~(SF^OF)
    - 6 -> ~(SF^OF)&~ZF
    - 7..15 -> 0
  - For all other codes cnd is latched 0. cnd then holds until the next EXECUTE exit.
- MEMORY: dmem_error=1 -> stat=ADR, go to HALTED (writeback skipped). Otherwise -> WRITEBACK -> PC_UPD.
- PC_UPD: instr_count += 1, wrapping modulo 2^CNT_W, then -> FETCH. start is ignored outside IDLE.
- HALTED: halted=1, state and stat held until reset.

Decomposition:
- Package y86_pkg holds:
  - icode constants: HALT=0, NOP=1, CMOVXX=2, IRMOVQ=3, RMMOVQ=4, MRMOVQ=5, OPQ=6, JXX=7, CALL=8, RET=9, PUSHQ=10, POPQ=11.
  - ALU fun codes (ADD=0, SUB=1, AND=2, XOR=3).
  - Condition fun codes 0..6.
  - stat codes.
  - State enum.
- Sub-module cond_eval: combinational, input cc and fun, output cnd. It is reusable by a later pipelined core.

Test Plan:
- Reset then start=1 with in_code=6, fun=1, a=10, b=50, e=40 -> enables one-hot for 6 consecutive cycles, cc=000, instr_count=1 after PC_UPD, back in FETCH.
- OPq fun=1, a=50, b=50, e=0 -> cc=100. Next instruction in_code=2, fun=3 -> cnd=1. Then in_code=2, fun=4 -> cnd=0.
- addq a=0x7FFF_FFFF_FFFF_FFFF, b=1, e=0x8000_0000_0000_0000 -> cc=011 (SF=1, OF=1). Then in_code=7, fun=2 (jl) -> cnd=0. Then fun=1 (jle) -> cnd=0.
- in_code=0 at FETCH -> stat=2 (HLT), halted=1 next cycle, all enables 0, instr_count unchanged. start pulses are ignored until reset.
- Faults: imem_error=1 in FETCH -> stat=3. instr_valid=0 -> stat=4. dmem_error=1 in MEMORY -> stat=3, wb_en never asserted, cc retains its EXECUTE update.
- Reset asserted during EXECUTE of OPq with e=0 -> next cycle state IDLE, cc=100, cnd=0, stat=1, instr_count=0.
